// File: rtl/dac_enc_pkg.sv
// dac_enc_pkg -- rev 1.0
// Shared constants, types and binary-line mapping for the segmented DAC encoder.
`default_nettype none

package dac_enc_pkg;

  localparam int N_THERM  = 17;
  localparam int N_BIN    = 6;
  localparam int CODE_W   = 11;
  localparam int CODE_MAX = 1151;
  localparam int UNIT_LSB = 64;
  localparam int PTR_W    = 5;
  localparam int NSEL_W   = 5;

  typedef enum logic [1:0] {
    TP_NORMAL = 2'd0,
    TP_RAMP   = 2'd1
  } tp_mode_e;

  typedef logic [0:N_THERM-1] therm_t;
  typedef logic [0:N_BIN]     bin_t;

  // Line order is {binary_0, binary_0_red, binary_1..binary_5}; the LSB lands on exactly one of
  // the first two lines depending on which half of the split LSB cell is in use.
  function automatic bin_t map_binary(input logic [N_BIN-1:0] b, input logic red_sel);
    bin_t r;
    r    = '0;
    r[0] = red_sel ? 1'b0 : b[0];
    r[1] = red_sel ? b[0] : 1'b0;
    for (int i = 1; i < N_BIN; i++) begin
      r[i+1] = b[i];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dac_dem_rotator.sv
// dac_dem_rotator -- rev 1.0
// Combinational DWA cell selector: marks n cells starting at ptr (mod 17) and computes next ptr.
`default_nettype none

module dac_dem_rotator
  import dac_enc_pkg::*;
(
  input  logic [NSEL_W-1:0] n,
  input  logic [PTR_W-1:0]  ptr,
  input  logic              dem_en,
  output therm_t            mask,
  output logic [PTR_W-1:0]  ptr_next
);

  logic [5:0] ptr_ext;
  logic [5:0] sum;
  logic [5:0] sum_wrapped;

  assign ptr_ext = {1'b0, ptr};

  // A cell is selected when its distance ahead of ptr, modulo 17, is below n.
  for (genvar j = 0; j < N_THERM; j++) begin : g_cell
    logic [5:0] off;
    assign off     = (ptr_ext <= 6'(j)) ? (6'(j) - ptr_ext) : (6'(j + N_THERM) - ptr_ext);
    assign mask[j] = (off < {1'b0, n});
  end

  assign sum         = ptr_ext + {1'b0, n};
  assign sum_wrapped = (sum >= 6'(N_THERM)) ? (sum - 6'(N_THERM)) : sum;
  assign ptr_next    = dem_en ? sum_wrapped[PTR_W-1:0] : ptr;

endmodule

`default_nettype wire

// File: rtl/dac_segment_encoder.sv
// dac_segment_encoder -- rev 1.0
// Two-stage saturating therm/binary encoder with DWA rotation, ramp pattern and power-down.
`default_nettype none

module dac_segment_encoder
  import dac_enc_pkg::*;
(
  input  logic              clkin,
  input  logic              rstb,
  input  logic              pdb,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  input  logic              dem_en,
  input  logic [1:0]        tp_mode,
  input  logic              lsb_red_sel,
  output therm_t            dataintherm,
  output therm_t            datainthermb,
  output bin_t              datainbin,
  output bin_t              datainbinb,
  output logic              out_valid,
  output logic              sat_flag
);

  logic              ramp_mode;
  logic              accept;
  logic              sat_raw;
  logic [CODE_W-1:0] code_c;

  logic [CODE_W-1:0] ramp_d,     ramp_q;
  logic              s1_valid_d, s1_valid_q;
  logic [NSEL_W-1:0] n_d,        n_q;
  logic [N_BIN-1:0]  b_d,        b_q;
  logic              s1_sat_d,   s1_sat_q;

  logic [PTR_W-1:0]  ptr_d,      ptr_q;
  therm_t            therm_d,    therm_q;
  therm_t            thermb_d,   thermb_q;
  bin_t              bin_d,      bin_q;
  bin_t              binb_d,     binb_q;
  logic              valid_d,    valid_q;
  logic              sat_d,      sat_q;

  therm_t            rot_mask;
  logic [PTR_W-1:0]  rot_ptr_next;

  // Stage 1: source select, saturation and field split. Reserved modes decode as normal.
  always_comb begin
    ramp_mode  = (tp_mode == TP_RAMP);
    accept     = ramp_mode | code_valid;
    sat_raw    = !ramp_mode && (code_in > CODE_W'(CODE_MAX));
    code_c     = ramp_mode ? ramp_q : (sat_raw ? CODE_W'(CODE_MAX) : code_in);
    if (!pdb) begin
      code_c  = '0;
      sat_raw = 1'b0;
    end

    ramp_d = ramp_q;
    if (!ramp_mode) begin
      ramp_d = '0;
    end else if (pdb) begin
      ramp_d = (ramp_q == CODE_W'(CODE_MAX)) ? '0 : ramp_q + 1'b1;
    end

    s1_valid_d = accept;
    n_d        = n_q;
    b_d        = b_q;
    s1_sat_d   = s1_sat_q;
    if (accept) begin
      n_d      = code_c[CODE_W-1:N_BIN];
      b_d      = code_c[N_BIN-1:0];
      s1_sat_d = sat_raw;
    end
  end

  dac_dem_rotator u_rotator (
    .n        (n_q),
    .ptr      (ptr_q),
    .dem_en   (dem_en),
    .mask     (rot_mask),
    .ptr_next (rot_ptr_next)
  );

  // Stage 2: outputs and complements share one flop stage; without a word they hold.
  always_comb begin
    ptr_d    = ptr_q;
    therm_d  = therm_q;
    thermb_d = thermb_q;
    bin_d    = bin_q;
    binb_d   = binb_q;
    sat_d    = sat_q;
    valid_d  = 1'b0;
    if (s1_valid_q) begin
      ptr_d    = rot_ptr_next;
      therm_d  = rot_mask;
      thermb_d = ~rot_mask;
      bin_d    = map_binary(b_q, lsb_red_sel);
      binb_d   = ~map_binary(b_q, lsb_red_sel);
      sat_d    = s1_sat_q;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clkin) begin
    if (!rstb) begin
      ramp_q     <= '0;
      s1_valid_q <= 1'b0;
      n_q        <= '0;
      b_q        <= '0;
      s1_sat_q   <= 1'b0;
      ptr_q      <= '0;
      therm_q    <= '0;
      thermb_q   <= '1;
      bin_q      <= '0;
      binb_q     <= '1;
      valid_q    <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      ramp_q     <= ramp_d;
      s1_valid_q <= s1_valid_d;
      n_q        <= n_d;
      b_q        <= b_d;
      s1_sat_q   <= s1_sat_d;
      ptr_q      <= ptr_d;
      therm_q    <= therm_d;
      thermb_q   <= thermb_d;
      bin_q      <= bin_d;
      binb_q     <= binb_d;
      valid_q    <= valid_d;
      sat_q      <= sat_d;
    end
  end

  assign dataintherm  = therm_q;
  assign datainthermb = thermb_q;
  assign datainbin    = bin_q;
  assign datainbinb   = binb_q;
  assign out_valid    = valid_q;
  assign sat_flag     = sat_q;

endmodule

`default_nettype wire
